// File: rtl/serial_feeder_pkg.sv
// serial_feeder_pkg: state encoding, default word width and counter sizing for serial_word_feeder.
package serial_feeder_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
   localparam int DEFAULT_WIDTH = 8;
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction
endpackage

// File: rtl/serial_word_feeder.sv
// serial_word_feeder: valid/ready word in, one bit per clock out on j/j_valid, gapless back-to-back.
// Define SERIAL_FEEDER_PARITY_EN to append an even-parity bit to every frame.
module serial_word_feeder
   import serial_feeder_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             j,
   output logic             j_valid,
   output logic             busy
);
   localparam int CW = cnt_width(WIDTH);
`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int LAST = WIDTH;
   logic par;
`else
   localparam int LAST = WIDTH - 1;
`endif
   state_t state, state_nx;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0] cnt;
   logic last, xfer, data_bit;
   assign last      = (state == SHIFT) && (cnt == CW'(LAST));
   assign din_ready = (state == IDLE) || last;
   assign xfer      = din_valid && din_ready;
   assign j_valid   = (state == SHIFT);
   assign busy      = (state != IDLE);
   assign data_bit  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
`ifdef SERIAL_FEEDER_PARITY_EN
   assign j = (state != SHIFT) ? IDLE_BIT : (cnt == CW'(WIDTH)) ? par : data_bit;
`else
   assign j = (state != SHIFT) ? IDLE_BIT : data_bit;
`endif
   // A word boundary (idle or last bit) is the only place the next state can change.
   always_comb begin
      state_nx = state;
      state_nx = din_ready ? (xfer ? SHIFT : IDLE) : state;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         if (xfer) begin
            shreg <= din;
            cnt   <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
            par   <= ^din;
`endif
         end else if (state == SHIFT) begin
            shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
            cnt   <= last ? '0 : cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_serial_word_feeder.sv
// tb_serial_word_feeder: directed checks of serialization, handshake, back-to-back, async reset and bit order.
module tb_serial_word_feeder;
`ifdef SERIAL_FEEDER_PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif
   logic clk = 1'b0, rst = 1'b0, din_valid = 1'b0;
   logic [7:0] din = 8'h00;
   logic j, j_valid, din_ready, busy;
   logic jl, jl_valid, rdy_l, busy_l;
   int n_cmp = 0, n_fail = 0;

   always #5 clk = ~clk;

   serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(din_ready), .j(j), .j_valid(j_valid), .busy(busy));

   serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
      .din_ready(rdy_l), .j(jl), .j_valid(jl_valid), .busy(busy_l));

   task automatic send(input logic [7:0] w);
      @(posedge clk); #1 din = w; din_valid = 1'b1;
      @(posedge clk); #1 din_valid = 1'b0;
   endtask

   // seq lists the expected data bits in emission order, seq[7] first.
   task automatic check_frame(input logic [7:0] seq, input logic par, input string nm,
                              input int inj, input logic [7:0] inj_word, input bit det_chk);
      logic [4:0] h;
      logic e;
      h = '0;
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         e = (i < 8) ? seq[7-i] : par;
         n_cmp++; if (j_valid !== 1'b1) begin n_fail++; $display("FAIL %s j_valid bit%0d got %b want 1", nm, i, j_valid); end
         n_cmp++; if (j !== e) begin n_fail++; $display("FAIL %s j bit%0d got %b want %b", nm, i, j, e); end
         n_cmp++; if (din_ready !== (i == FL-1)) begin n_fail++; $display("FAIL %s din_ready bit%0d got %b want %b", nm, i, din_ready, (i == FL-1)); end
         n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy bit%0d got %b want 1", nm, i, busy); end
         if (det_chk) begin
            h = {h[3:0], j};
            n_cmp++; if (((i >= 4) && (h == 5'b10010)) !== (i == 4)) begin n_fail++; $display("FAIL %s detector bit%0d got %b want %b", nm, i, (h == 5'b10010), (i == 4)); end
         end
         if (i == inj) begin din = inj_word; din_valid = 1'b1; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      #12;
      n_cmp++; if (j_valid !== 1'b0) begin n_fail++; $display("FAIL reset j_valid got %b want 0", j_valid); end
      n_cmp++; if (j !== 1'b0) begin n_fail++; $display("FAIL reset j got %b want 0", j); end
      n_cmp++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL reset din_ready got %b want 1", din_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_single;
      send(8'h90);
      check_frame(8'b1001_0000, 1'b0, "single", -1, 8'h00, 1'b1);
      @(negedge clk);
      n_cmp++; if (j_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle j_valid got %b want 0", j_valid); end
      n_cmp++; if (j !== 1'b0) begin n_fail++; $display("FAIL single_idle j got %b want 0", j); end
      n_cmp++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL single_idle din_ready got %b want 1", din_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle busy got %b want 0", busy); end
   endtask

   task automatic test_back_to_back;
      @(posedge clk); #1 din = 8'h92; din_valid = 1'b1;
      @(posedge clk); #1 din = 8'h48;
      check_frame(8'b1001_0010, 1'b1, "b2b_first", -1, 8'h00, 1'b0);
      @(posedge clk); #1 din_valid = 1'b0;
      check_frame(8'b0100_1000, 1'b0, "b2b_second", -1, 8'h00, 1'b0);
      @(negedge clk);
      n_cmp++; if (j_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end j_valid got %b want 0", j_valid); end
   endtask

   task automatic test_hold;
      send(8'h92);
      check_frame(8'b1001_0010, 1'b1, "hold_cur", 2, 8'hFF, 1'b0);
      @(posedge clk); #1 din_valid = 1'b0;
      check_frame(8'b1111_1111, 1'b0, "hold_next", -1, 8'h00, 1'b0);
      @(negedge clk);
      n_cmp++; if (j_valid !== 1'b0) begin n_fail++; $display("FAIL hold_end j_valid got %b want 0", j_valid); end
   endtask

   task automatic test_reset_mid_word;
      send(8'hA5);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_cmp++; if (j_valid !== 1'b0) begin n_fail++; $display("FAIL midrst j_valid got %b want 0", j_valid); end
      n_cmp++; if (j !== 1'b0) begin n_fail++; $display("FAIL midrst j got %b want 0", j); end
      n_cmp++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL midrst din_ready got %b want 1", din_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst busy got %b want 0", busy); end
      n_cmp++; if (jl_valid !== 1'b0) begin n_fail++; $display("FAIL midrst lsb j_valid got %b want 0", jl_valid); end
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         n_cmp++; if (j_valid !== 1'b0 || j !== 1'b0) begin n_fail++; $display("FAIL post_rst cycle%0d j_valid/j got %b/%b want 0/0", i, j_valid, j); end
         n_cmp++; if (din_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst cycle%0d din_ready got %b want 1", i, din_ready); end
      end
      send(8'h3C);
      check_frame(8'b0011_1100, 1'b0, "post_rst_word", -1, 8'h00, 1'b0);
   endtask

   task automatic test_lsb_first;
      logic [7:0] seq;
      logic e;
      seq = 8'b1100_0000;
      send(8'h03);
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         e = (i < 8) ? seq[7-i] : 1'b0;
         n_cmp++; if (jl_valid !== 1'b1) begin n_fail++; $display("FAIL lsb j_valid bit%0d got %b want 1", i, jl_valid); end
         n_cmp++; if (jl !== e) begin n_fail++; $display("FAIL lsb j bit%0d got %b want %b", i, jl, e); end
         n_cmp++; if (rdy_l !== (i == FL-1)) begin n_fail++; $display("FAIL lsb din_ready bit%0d got %b want %b", i, rdy_l, (i == FL-1)); end
      end
      @(negedge clk);
      n_cmp++; if (jl_valid !== 1'b0 || busy_l !== 1'b0) begin n_fail++; $display("FAIL lsb_end j_valid/busy got %b/%b want 0/0", jl_valid, busy_l); end
   endtask

`ifdef SERIAL_FEEDER_PARITY_EN
   task automatic test_parity;
      send(8'h93);
      check_frame(8'b1001_0011, 1'b0, "parity_93", -1, 8'h00, 1'b0);
      send(8'h92);
      check_frame(8'b1001_0010, 1'b1, "parity_92", -1, 8'h00, 1'b0);
   endtask
`endif

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_hold;
      test_reset_mid_word;
      test_lsb_first;
`ifdef SERIAL_FEEDER_PARITY_EN
      test_parity;
`endif
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
